// File: rtl/clarvi_bridge_pkg.sv
// Shared types and constants for the clarvi variable-latency bridge.
package clarvi_bridge_pkg;

   localparam int BRIDGE_ADDR_WIDTH = 14;
   localparam logic [31:0] BRIDGE_TIMEOUT_DATA = 32'hDEADBEEF;

   typedef enum logic [2:0] {
      IDLE,
      ISSUE,
      WAIT_DATA,
      DONE,
      RESP
   } bridge_state_t;

   typedef struct packed {
      logic [BRIDGE_ADDR_WIDTH-1:0] addr;
      logic [3:0]                   byteenable;
      logic [31:0]                  writedata;
      logic                         is_write;
   } bridge_req_t;

   function automatic int bridge_timer_width(input int cycles);
      return $clog2(cycles + 1);
   endfunction

endpackage

// File: rtl/clarvi_bridge_timer.sv
// Loadable saturating down-counter; expired_o flags the last enabled cycle
// once the count has run down to zero.
module clarvi_bridge_timer #(
   parameter int WIDTH = 11
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             load_i,
   input  logic [WIDTH-1:0] load_val_i,
   input  logic             en_i,
   output logic             expired_o
);

   logic [WIDTH-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load_i)
         cnt_d = load_val_i;
      else if (en_i && (cnt_q != '0))
         cnt_d = cnt_q - WIDTH'(1);
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) cnt_q <= '0;
      else       cnt_q <= cnt_d;
   end

   assign expired_o = en_i && (cnt_q == '0);

endmodule

// File: rtl/clarvi_latency_bridge.sv
// Hides variable slave latency from the fixed 1-cycle-latency clarvi core.
// Define BRIDGE_TIMEOUT_EN to abort transactions stuck for TIMEOUT_CYCLES.
module clarvi_latency_bridge
   import clarvi_bridge_pkg::*;
#(
   parameter int ADDR_WIDTH     = BRIDGE_ADDR_WIDTH,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic [ADDR_WIDTH-1:0] avs_address,
   input  logic [3:0]            avs_byteenable,
   input  logic                  avs_read,
   input  logic                  avs_write,
   input  logic [31:0]           avs_writedata,
   output logic                  avs_waitrequest,
   output logic [31:0]           avs_readdata,
   output logic                  avs_readdatavalid,
   output logic [ADDR_WIDTH-1:0] avm_address,
   output logic [3:0]            avm_byteenable,
   output logic                  avm_read,
   output logic                  avm_write,
   output logic [31:0]           avm_writedata,
   input  logic                  avm_waitrequest,
   input  logic [31:0]           avm_readdata,
   input  logic                  avm_readdatavalid,
   output logic                  timeout_error
);

   bridge_state_t state_q, state_d;
   bridge_req_t   req_q, req_d;
   logic [31:0]   rdata_q, rdata_d;
   logic          avm_read_q, avm_write_q;
   logic          tmo_expire;

`ifdef BRIDGE_TIMEOUT_EN
   localparam int TMR_W = bridge_timer_width(TIMEOUT_CYCLES);
   // Loaded one short so expiry lands on the TIMEOUT_CYCLES-th busy cycle.
   localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(TIMEOUT_CYCLES - 1);

   logic tmr_load, tmr_en;
   logic tmo_err_q;

   assign tmr_load = (state_d == ISSUE) && (state_q != ISSUE);
   assign tmr_en   = (state_q == ISSUE) || (state_q == WAIT_DATA);

   clarvi_bridge_timer #(
      .WIDTH (TMR_W)
   ) u_timer (
      .clock      (clock),
      .reset      (reset),
      .load_i     (tmr_load),
      .load_val_i (TMR_LOAD),
      .en_i       (tmr_en),
      .expired_o  (tmo_expire)
   );

   always_ff @(posedge clock or posedge reset) begin
      if (reset)           tmo_err_q <= 1'b0;
      else if (tmo_expire) tmo_err_q <= 1'b1;
   end

   assign timeout_error = tmo_err_q;
`else
   assign tmo_expire    = 1'b0;
   assign timeout_error = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      req_d   = req_q;
      rdata_d = rdata_q;
      case (state_q)
         IDLE, RESP: begin
            state_d = IDLE;
            if (avs_read || avs_write) begin
               req_d.addr       = BRIDGE_ADDR_WIDTH'(avs_address);
               req_d.byteenable = avs_byteenable;
               req_d.writedata  = avs_writedata;
               req_d.is_write   = avs_write;
               state_d          = ISSUE;
            end
         end
         ISSUE: begin
            if (tmo_expire) begin
               state_d = DONE;
               if (!req_q.is_write) rdata_d = BRIDGE_TIMEOUT_DATA;
            end else if (!avm_waitrequest) begin
               state_d = req_q.is_write ? DONE : WAIT_DATA;
            end
         end
         WAIT_DATA: begin
            if (tmo_expire) begin
               state_d = DONE;
               rdata_d = BRIDGE_TIMEOUT_DATA;
            end else if (avm_readdatavalid) begin
               state_d = DONE;
               rdata_d = avm_readdata;
            end
         end
         DONE:    state_d = req_q.is_write ? IDLE : RESP;
         default: state_d = IDLE;
      endcase
   end

   // Slave strobes are registered from the next state so they never see a
   // combinational path from the core side.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         req_q       <= '0;
         rdata_q     <= '0;
         avm_read_q  <= 1'b0;
         avm_write_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         req_q       <= req_d;
         rdata_q     <= rdata_d;
         avm_read_q  <= (state_d == ISSUE) && !req_d.is_write;
         avm_write_q <= (state_d == ISSUE) &&  req_d.is_write;
      end
   end

   assign avs_waitrequest   = (state_q != DONE);
   assign avs_readdatavalid = (state_q == RESP);
   assign avs_readdata      = rdata_q;

   assign avm_address    = ADDR_WIDTH'(req_q.addr);
   assign avm_byteenable = req_q.byteenable;
   assign avm_writedata  = req_q.writedata;
   assign avm_read       = avm_read_q;
   assign avm_write      = avm_write_q;

endmodule

// File: tb/tb_clarvi_latency_bridge.sv
// Directed bench: per-cycle expectations derived from the bridge latency
// rules, checked every cycle, plus a few literal pins at known cycles.
module tb_clarvi_latency_bridge;

   localparam int NC = 120;
   localparam int AW = 14;
`ifdef BRIDGE_TIMEOUT_EN
   localparam int TMO = 8;
`else
   localparam int TMO = 1024;
`endif

   logic          clock = 1'b0;
   logic          reset;
   logic [AW-1:0] avs_address;
   logic [3:0]    avs_byteenable;
   logic          avs_read, avs_write;
   logic [31:0]   avs_writedata;
   logic          avs_waitrequest;
   logic [31:0]   avs_readdata;
   logic          avs_readdatavalid;
   logic [AW-1:0] avm_address;
   logic [3:0]    avm_byteenable;
   logic          avm_read, avm_write;
   logic [31:0]   avm_writedata;
   logic          avm_waitrequest;
   logic [31:0]   avm_readdata;
   logic          avm_readdatavalid;
   logic          timeout_error;

   always #5 clock = ~clock;

   clarvi_latency_bridge #(
      .ADDR_WIDTH     (AW),
      .TIMEOUT_CYCLES (TMO)
   ) dut (
      .clock             (clock),
      .reset             (reset),
      .avs_address       (avs_address),
      .avs_byteenable    (avs_byteenable),
      .avs_read          (avs_read),
      .avs_write         (avs_write),
      .avs_writedata     (avs_writedata),
      .avs_waitrequest   (avs_waitrequest),
      .avs_readdata      (avs_readdata),
      .avs_readdatavalid (avs_readdatavalid),
      .avm_address       (avm_address),
      .avm_byteenable    (avm_byteenable),
      .avm_read          (avm_read),
      .avm_write         (avm_write),
      .avm_writedata     (avm_writedata),
      .avm_waitrequest   (avm_waitrequest),
      .avm_readdata      (avm_readdata),
      .avm_readdatavalid (avm_readdatavalid),
      .timeout_error     (timeout_error)
   );

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   bit run   = 0;

   // stimulus schedule
   logic          r_rst [NC];
   logic          c_rd [NC], c_wr [NC];
   logic [AW-1:0] c_addr [NC];
   logic [3:0]    c_be [NC];
   logic [31:0]   c_wd [NC];
   logic          s_wait [NC], s_rdv [NC];
   logic [31:0]   s_data [NC];
   // expected outputs
   logic          e_wreq [NC], e_rdv [NC], e_rdchk [NC], e_achk [NC];
   logic          e_aread [NC], e_awrite [NC], e_terr [NC];
   logic [31:0]   e_rdata [NC], e_wd [NC];
   logic [AW-1:0] e_addr [NC];
   logic [3:0]    e_be [NC];

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s cyc=%0d got=%h want=%h", nm, cyc, got, exp);
      end
   endtask

   task automatic clear_exp(input int c0, input int c1);
      for (int c = c0; c <= c1; c++) begin
         e_wreq[c] = 1'b1; e_rdv[c] = 1'b0; e_rdchk[c] = 1'b0; e_achk[c] = 1'b0;
         e_aread[c] = 1'b0; e_awrite[c] = 1'b0; e_terr[c] = 1'b0;
         e_rdata[c] = '0; e_wd[c] = '0; e_addr[c] = '0; e_be[c] = '0;
      end
   endtask

   // One core transaction: request at t0, slave stalls s cycles then accepts,
   // read data arrives l cycles after acceptance.
   task automatic add_txn(input int t0, input bit wr, input bit rd, input int s, input int l,
                          input logic [AW-1:0] a, input logic [3:0] be,
                          input logic [31:0] wd, input logic [31:0] d);
      int acc, w;
      acc = t0 + 1 + s;
      for (int c = t0 + 1; c <= acc; c++) begin
         s_wait[c] = (c < acc);
         e_aread[c] = !wr; e_awrite[c] = wr; e_achk[c] = 1'b1;
         e_addr[c] = a; e_be[c] = be; e_wd[c] = wd;
      end
      if (wr) begin
         w = acc + 1;
      end else begin
         s_rdv[acc + l] = 1'b1; s_data[acc + l] = d;
         w = acc + l + 1;
         e_rdv[w + 1] = 1'b1; e_rdata[w + 1] = d; e_rdchk[w + 1] = 1'b1;
      end
      e_wreq[w] = 1'b0;
      for (int c = t0; c <= w; c++) begin
         c_rd[c] = rd; c_wr[c] = wr; c_addr[c] = a; c_be[c] = be; c_wd[c] = wd;
      end
   endtask

   // Reset held r0..r1; everything in flight is forgotten up to cend.
   task automatic apply_reset(input int r0, input int r1, input int cend);
      clear_exp(r0, cend);
      for (int c = r0; c <= cend; c++) begin
         e_rdchk[c] = 1'b1; e_achk[c] = 1'b1;
         if (c <= r1) r_rst[c] = 1'b1;
         c_rd[c] = 1'b0; c_wr[c] = 1'b0;
      end
   endtask

   initial begin
      for (int c = 0; c < NC; c++) begin
         r_rst[c] = 1'b0; c_rd[c] = 1'b0; c_wr[c] = 1'b0;
         c_addr[c] = '0; c_be[c] = '0; c_wd[c] = '0;
         s_wait[c] = 1'b0; s_rdv[c] = 1'b0; s_data[c] = '0;
      end
      clear_exp(0, NC - 1);
      apply_reset(0, 2, 4);
      add_txn(5,  1'b0, 1'b1, 0, 1, 14'h010, 4'hF, 32'h0, 32'h12345678);
      add_txn(12, 1'b1, 1'b0, 3, 0, 14'h2A5, 4'b0011, 32'hCAFEF00D, 32'h0);
      add_txn(22, 1'b0, 1'b1, 0, 5, 14'h100, 4'hF, 32'h0, 32'hAAAA0001);
      add_txn(30, 1'b0, 1'b1, 0, 2, 14'h101, 4'hF, 32'h0, 32'hBBBB0002);
      add_txn(40, 1'b0, 1'b1, 2, 3, 14'h1C7, 4'b1100, 32'h0, 32'h5A5AC3C3);
      add_txn(52, 1'b1, 1'b1, 0, 0, 14'h3F0, 4'b0101, 32'h600DF00D, 32'h0);
      add_txn(60, 1'b0, 1'b1, 0, 10, 14'h3FF, 4'hF, 32'h0, 32'h11112222);
      apply_reset(64, 65, 75);
      add_txn(76, 1'b0, 1'b1, 0, 1, 14'h055, 4'hF, 32'h0, 32'h0BADF00D);
      // slave never answers a read issued at 90
      for (int c = 91; c < NC; c++) s_wait[c] = 1'b1;
`ifdef BRIDGE_TIMEOUT_EN
      for (int c = 90; c <= 90 + TMO + 1; c++) begin c_rd[c] = 1'b1; c_addr[c] = 14'h0AB; c_be[c] = 4'hF; end
      for (int c = 91; c <= 90 + TMO; c++) begin
         e_aread[c] = 1'b1; e_achk[c] = 1'b1; e_addr[c] = 14'h0AB; e_be[c] = 4'hF;
      end
      e_wreq[91 + TMO] = 1'b0;
      e_rdv[92 + TMO] = 1'b1; e_rdata[92 + TMO] = 32'hDEADBEEF; e_rdchk[92 + TMO] = 1'b1;
      for (int c = 91 + TMO; c <= 109; c++) e_terr[c] = 1'b1;
`else
      for (int c = 90; c <= 109; c++) begin c_rd[c] = 1'b1; c_addr[c] = 14'h0AB; c_be[c] = 4'hF; end
      for (int c = 91; c <= 109; c++) begin
         e_aread[c] = 1'b1; e_achk[c] = 1'b1; e_addr[c] = 14'h0AB; e_be[c] = 4'hF;
      end
`endif
      apply_reset(110, 111, NC - 1);

      reset = 1'b1; avs_read = 1'b0; avs_write = 1'b0;
      avs_address = '0; avs_byteenable = '0; avs_writedata = '0;
      avm_waitrequest = 1'b0; avm_readdatavalid = 1'b0; avm_readdata = '0;
      for (int c = 0; c < NC; c++) begin
         @(negedge clock);
         cyc = c; run = 1'b1;
         reset = r_rst[c];
         avs_read = c_rd[c]; avs_write = c_wr[c];
         avs_address = c_addr[c]; avs_byteenable = c_be[c]; avs_writedata = c_wd[c];
         avm_waitrequest = s_wait[c]; avm_readdatavalid = s_rdv[c]; avm_readdata = s_data[c];
      end
      @(negedge clock);
      run = 1'b0;
      #2;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   always @(negedge clock) begin
      #1;
      if (run) begin
         chk("waitrequest", avs_waitrequest, e_wreq[cyc]);
         chk("readdatavalid", avs_readdatavalid, e_rdv[cyc]);
         chk("avm_read", avm_read, e_aread[cyc]);
         chk("avm_write", avm_write, e_awrite[cyc]);
         chk("timeout_error", timeout_error, e_terr[cyc]);
         if (e_rdchk[cyc]) chk("readdata", avs_readdata, e_rdata[cyc]);
         if (e_achk[cyc]) begin
            chk("avm_address", avm_address, e_addr[cyc]);
            chk("avm_byteenable", avm_byteenable, e_be[cyc]);
            chk("avm_writedata", avm_writedata, e_wd[cyc]);
         end
         case (cyc)
            1:  chk("pin_reset_wreq", avs_waitrequest, 1'b1);
            6:  chk("pin_t1_avm_read", avm_read, 1'b1);
            8:  chk("pin_t1_wreq_low", avs_waitrequest, 1'b0);
            9:  chk("pin_t1_rdata", avs_readdata, 32'h12345678);
            16: chk("pin_t2_wdata", avm_writedata, 32'hCAFEF00D);
            17: chk("pin_t2_wreq_low", avs_waitrequest, 1'b0);
            18: chk("pin_t2_no_rdv", avs_readdatavalid, 1'b0);
            30: chk("pin_t3_rdata", avs_readdata, 32'hAAAA0001);
            31: chk("pin_t4_addr", avm_address, 14'h101);
            35: chk("pin_t4_rdata", avs_readdata, 32'hBBBB0002);
            64: chk("pin_rst_avm_read", avm_read, 1'b0);
            72: chk("pin_stale_rdata", avs_readdata, 32'h0);
`ifdef BRIDGE_TIMEOUT_EN
            99:  chk("pin_tmo_wreq_low", avs_waitrequest, 1'b0);
            100: chk("pin_tmo_rdata", avs_readdata, 32'hDEADBEEF);
            105: chk("pin_tmo_sticky", timeout_error, 1'b1);
`else
            105: chk("pin_wait_forever", avm_read, 1'b1);
`endif
            default: ;
         endcase
      end
   end

endmodule
